// File: rtl/fc_seq_ctrl.sv
// fc_seq_ctrl: sequencer around a fully-connected layer datapath.
// Collects IN activations from a valid/ready stream into x_bus, waits SETTLE cycles for the
// combinational layer datapath, captures all neuron outputs from z_bus, then drains them one
// word at a time with a neuron index.
// Optional feature: define FC_SEQ_ARGMAX_EN to add the cls/cls_valid argmax outputs.
module fc_seq_ctrl #(
   parameter int WIDTH   = 8,
   parameter int IN      = 128,
   parameter int NEURONS = 10,
   parameter int Z_WIDTH = 23,
   parameter int SETTLE  = 2
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          s_valid,
   output logic                          s_ready,
   input  logic [WIDTH-1:0]              s_data,
   input  logic                          s_last,
   output logic [IN*WIDTH-1:0]           x_bus,
   input  logic [NEURONS*Z_WIDTH-1:0]    z_bus,
   output logic                          m_valid,
   input  logic                          m_ready,
   output logic [Z_WIDTH-1:0]            m_data,
   output logic [$clog2(NEURONS)-1:0]    m_idx,
   output logic                          m_last,
   output logic                          err
`ifdef FC_SEQ_ARGMAX_EN
   ,
   output logic [$clog2(NEURONS)-1:0]    cls,
   output logic                          cls_valid
`endif
);

   localparam int CW = (IN > 1) ? $clog2(IN) : 1;
   localparam int IW = $clog2(NEURONS);

   typedef enum logic [1:0] {
      StLoad,
      StSettle,
      StCapture,
      StDrain
   } state_e;

   state_e                       state;
   logic [CW-1:0]                cnt;
   logic [3:0]                   scnt;
   logic [IW-1:0]                idx;
   logic [NEURONS*Z_WIDTH-1:0]   obuf;

`ifdef FC_SEQ_ARGMAX_EN
   logic [IW-1:0]                amax;
   logic [Z_WIDTH-1:0]           amax_v;

   // Argmax over z_bus; strict compare keeps the lowest index on ties.
   always_comb begin
      amax   = '0;
      amax_v = z_bus[Z_WIDTH-1:0];
      for (int i = 1; i < NEURONS; i++) begin
         if (z_bus[i*Z_WIDTH +: Z_WIDTH] > amax_v) begin
            amax_v = z_bus[i*Z_WIDTH +: Z_WIDTH];
            amax   = IW'(i);
         end
      end
   end
`endif

   // Result word is selected straight from the captured buffer, so it holds while stalled.
   always_comb begin
      m_data = obuf[int'(idx)*Z_WIDTH +: Z_WIDTH];
      m_idx  = idx;
   end

   // Sequencer: load, settle, capture, drain; all outputs registered.
   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= StLoad;
         cnt     <= '0;
         scnt    <= '0;
         idx     <= '0;
         x_bus   <= '0;
         obuf    <= '0;
         s_ready <= 1'b0;
         m_valid <= 1'b0;
         m_last  <= 1'b0;
         err     <= 1'b0;
`ifdef FC_SEQ_ARGMAX_EN
         cls       <= '0;
         cls_valid <= 1'b0;
`endif
      end else begin
         case (state)
            StLoad: begin
               if (s_valid && s_ready) begin
                  x_bus[int'(cnt)*WIDTH +: WIDTH] <= s_data;
                  if (cnt == CW'(IN - 1)) begin
                     // Full vector: a missing s_last is a framing error but still completes.
                     if (!s_last) begin
                        err <= 1'b1;
                     end
                     cnt     <= '0;
                     s_ready <= 1'b0;
                     state   <= StSettle;
                  end else if (s_last) begin
                     // Short vector: clear the tail so stale data never reaches the datapath.
                     for (int i = 0; i < IN; i++) begin
                        if (i > int'(cnt)) begin
                           x_bus[i*WIDTH +: WIDTH] <= '0;
                        end
                     end
                     err     <= 1'b1;
                     cnt     <= '0;
                     s_ready <= 1'b0;
                     state   <= StSettle;
                  end else begin
                     cnt <= cnt + 1'b1;
                  end
               end else begin
                  s_ready <= 1'b1;
               end
            end

            StSettle: begin
               if (scnt == 4'(SETTLE - 1)) begin
                  scnt  <= '0;
                  state <= StCapture;
               end else begin
                  scnt <= scnt + 1'b1;
               end
            end

            StCapture: begin
               obuf    <= z_bus;
               idx     <= '0;
               m_valid <= 1'b1;
               m_last  <= (NEURONS == 1);
               state   <= StDrain;
`ifdef FC_SEQ_ARGMAX_EN
               cls       <= amax;
               cls_valid <= 1'b1;
`endif
            end

            StDrain: begin
               if (m_ready) begin
                  if (idx == IW'(NEURONS - 1)) begin
                     idx     <= '0;
                     m_valid <= 1'b0;
                     m_last  <= 1'b0;
                     s_ready <= 1'b1;
                     state   <= StLoad;
`ifdef FC_SEQ_ARGMAX_EN
                     cls_valid <= 1'b0;
`endif
                  end else begin
                     idx    <= idx + 1'b1;
                     m_last <= (idx == IW'(NEURONS - 2));
                  end
               end
            end

            default: begin
               state <= StLoad;
            end
         endcase
      end
   end

endmodule
